multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//   Multi-cycle sequencer for the RV32I datapath. Replaces the single-cycle decoder.
//   Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and shares one
//   memory port between instruction and data accesses (IorD) via a ready handshake.
//   Sits between the IR fields and the datapath muxes, register file and memory.
// PARAMETERS
//   MEM_TIMEOUT  16  max cycles waiting on MemReady in FETCH/MEM; 0 = never time out
// PORTS
//   clk          in   1  clock, all state on rising edge
//   rst          in   1  synchronous active-high reset
//   opcode       in   7  IR[6:0], stable from DECODE until instruction end
//   funct3       in   3  IR[14:12]
//   funct7       in   7  IR[31:25]
//   Zero         in   1  ALU zero flag, valid in EXEC
//   MemReady     in   1  memory completes the current MemRead/MemWrite this cycle
//   IorD         out  1  0 = memory address from PC, 1 = from ALU result
//   MemRead      out  1  memory read request, held until MemReady
//   MemWrite     out  1  memory write request, held until MemReady
//   IRWrite      out  1  latch fetched word into IR
//   PCWrite      out  1  PC <= PC+4 (dedicated adder)
//   BranchTaken  out  1  PC <= OldPC + imm
//   RegWrite     out  1  register file write
//   MemToReg     out  1  write-back source: 1 = memory data, 0 = ALU result
//   ALUSrc       out  1  ALU B operand: 1 = immediate, 0 = rs2
//   ALUctl       out  4  0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT
//   InstrDone    out  1  one-cycle pulse on the last cycle of each retired instruction
//   MemErr       out  1  sticky: memory timeout occurred
//   Halted       out  1  FSM is in HALT
//   Illegal      out  1  sticky illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
// - Registered state and timeout counter. Outputs are combinational from state + IR fields.
// - While rst=1, every output is 0 and ALUctl=0010. The cycle after rst falls is FETCH.
// - Outputs default to 0 and ALUctl=0010 in every state unless listed below.
// - FETCH: MemRead=1, IorD=0. On MemReady: IRWrite=1, PCWrite=1, next state DECODE.
// - DECODE: next state EXEC for opcodes 0110011 R, 0010011 I, 0000011 LD, 0100011 ST, 1100011 BR.
//   Any other opcode is illegal (see CONFIGURATION).
// - EXEC: drives ALUSrc and ALUctl.
//   - R: ALUSrc=0. I/LD/ST: ALUSrc=1. BR: ALUSrc=0.
//   - ALUctl for R and I:
//     - funct3 000: 0110 for R when funct7[5]=1; otherwise 0010.
//     - funct3 111: 0000. funct3 110: 0001. funct3 010: 0111. Other funct3: 0010.
//     - I ignores funct7.
//   - LD/ST: ALUctl=0010. BR: ALUctl=0110.
//   - R/I go to WB. LD/ST go to MEM.
//   - BR: BranchTaken = (funct3=000 & Zero) | (funct3=001 & !Zero). InstrDone=1. Next state FETCH.
// - MEM: IorD=1, ALUSrc=1, ALUctl=0010. LD asserts MemRead; ST asserts MemWrite.
//   Held until MemReady. Then LD goes to WB; ST pulses InstrDone and goes to FETCH.
// - WB: RegWrite=1, MemToReg=(opcode==LD), InstrDone=1, next state FETCH.
// - Latency with MemReady=1 on the first try: R/I 4 cycles, LD 5, ST 4, BR 3.
// - Timeout counter:
//   - Counts consecutive cycles in FETCH/MEM with MemReady=0.
//   - Clears on MemReady and on any state change.
//   - When it reaches MEM_TIMEOUT (nonzero): go to HALT, set MemErr.
//   - A MemReady arriving in the same cycle as the limit wins: no timeout.
// - HALT: all control outputs 0, Halted=1. Stays until rst. MemErr/Illegal cleared only by rst.
// - A reset asserted mid-instruction aborts it: no write strobe in the rst cycle, FETCH next.
// CONFIGURATION
//   ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE sets Illegal and goes to HALT.
//   ILLEGAL_TRAP_EN undefined: an illegal opcode is a NOP. DECODE goes to FETCH, InstrDone=0,
//     and Illegal is tied 0.
// TESTING
// - rst, then ADD (0110011, f7=0), MemReady high on the 3rd FETCH cycle -> DECODE, then EXEC
//   ALUctl=0010 ALUSrc=0, then WB RegWrite=1 InstrDone=1; 6 cycles in total.
// - SUB (f7=0100000) -> EXEC ALUctl=0110. ANDI (0010011, f3=111, f7=0100000) -> ALUctl=0000 ALUSrc=1.
// - LW (0000011, f3=010), MemReady=1 -> MEM MemRead=1 IorD=1, then WB MemToReg=1 RegWrite=1;
//   5 cycles, InstrDone on cycle 5.
// - BEQ with Zero=1 -> EXEC BranchTaken=1 ALUctl=0110 InstrDone=1; BNE with Zero=1 -> BranchTaken=0.
// - MEM_TIMEOUT=4, SW with MemReady held 0 in MEM -> after 4 MEM cycles Halted=1 MemErr=1
//   MemWrite=0; stays there until rst, then FETCH.
// - opcode 1111111: with ILLEGAL_TRAP_EN -> HALT, Illegal=1. Without it -> FETCH, InstrDone=0.
//   rst during SW MEM -> MemWrite=0 that cycle, FETCH next.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - IR fields, memory handshake and datapath control bundle
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       MemReady;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       BranchTaken;
    logic       RegWrite;
    logic       MemToReg;
    logic       ALUSrc;
    logic [3:0] ALUctl;
    logic       InstrDone;
    logic       MemErr;
    logic       Halted;
    logic       Illegal;

    modport master (
        output opcode, funct3, funct7, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, PCWrite, BranchTaken, RegWrite,
               MemToReg, ALUSrc, ALUctl, InstrDone, MemErr, Halted, Illegal
    );

    modport slave (
        input  opcode, funct3, funct7, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, PCWrite, BranchTaken, RegWrite,
               MemToReg, ALUSrc, ALUctl, InstrDone, MemErr, Halted, Illegal
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RV32I sequencer, optional ILLEGAL_TRAP_EN trap on bad opcodes
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.slave  bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Counter only ever holds MEM_TIMEOUT-1 before the halt decision is taken.
    localparam int unsigned   CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          illegal_q, illegal_d;

    logic       is_r, is_i, is_ld, is_st, is_br, legal;
    logic       mem_wait, timeout;
    logic [3:0] alu_ri;
    logic       unused_funct7;

    assign is_r  = (bus.opcode == OP_R);
    assign is_i  = (bus.opcode == OP_I);
    assign is_ld = (bus.opcode == OP_LD);
    assign is_st = (bus.opcode == OP_ST);
    assign is_br = (bus.opcode == OP_BR);
    assign legal = is_r | is_i | is_ld | is_st | is_br;
    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.MemReady;
    assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (cnt_q == LIMIT);

    always_comb begin
        alu_ri = ALU_ADD;
        case (bus.funct3)
            3'b000:  alu_ri = (is_r && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_ri = ALU_AND;
            3'b110:  alu_ri = ALU_OR;
            3'b010:  alu_ri = ALU_SLT;
            default: alu_ri = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = (mem_wait && !timeout) ? cnt_q + CW'(1) : '0;
        mem_err_d       = mem_err_q;
        illegal_d       = illegal_q;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.ALUSrc      = 1'b0;
        bus.ALUctl      = ALU_ADD;
        bus.InstrDone   = 1'b0;
        bus.Halted      = 1'b0;
        bus.MemErr      = mem_err_q;
        bus.Illegal     = illegal_q;

        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                if (bus.MemReady) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = S_DECODE;
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
`else
                    state_d   = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                bus.ALUSrc = is_i | is_ld | is_st;
                if (is_r || is_i) bus.ALUctl = alu_ri;
                else if (is_br)   bus.ALUctl = ALU_SUB;
                if (is_br) begin
                    bus.BranchTaken = ((bus.funct3 == 3'b000) &&  bus.Zero) ||
                                      ((bus.funct3 == 3'b001) && !bus.Zero);
                    bus.InstrDone   = 1'b1;
                    state_d         = S_FETCH;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.IorD     = 1'b1;
                bus.ALUSrc   = 1'b1;
                bus.MemRead  = is_ld;
                bus.MemWrite = is_st;
                if (bus.MemReady) begin
                    if (is_ld) begin
                        state_d = S_WB;
                    end else begin
                        bus.InstrDone = 1'b1;
                        state_d       = S_FETCH;
                    end
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_WB: begin
                bus.RegWrite  = 1'b1;
                bus.MemToReg  = is_ld;
                bus.InstrDone = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT: begin
                bus.Halted = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // Reset masks everything so an aborted instruction never strobes a write.
        if (rst) begin
            bus.IorD        = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.PCWrite     = 1'b0;
            bus.BranchTaken = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.MemToReg    = 1'b0;
            bus.ALUSrc      = 1'b0;
            bus.ALUctl      = ALU_ADD;
            bus.InstrDone   = 1'b0;
            bus.Halted      = 1'b0;
            bus.MemErr      = 1'b0;
            bus.Illegal     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
            illegal_q <= illegal_d;
        end
    end
endmodule
